// File: rtl/ft232h_sync_bridge_pkg.sv
// Shared types and constants for the FT232H synchronous 245-FIFO bridge.
// Active-level constants keep strobe polarity readable at every use site.
package ft232h_sync_bridge_pkg;

   localparam int DATA_W = 8;

   localparam logic ENABLE    = 1'b1;
   localparam logic DISABLE   = 1'b0;
   localparam logic ENABLE_N  = 1'b0;
   localparam logic DISABLE_N = 1'b1;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      TX_FETCH = 3'd1,
      TX_SEND  = 3'd2,
      RX_OE    = 3'd3,
      RX       = 3'd4
   } ft_state_t;

endpackage : ft232h_sync_bridge_pkg

// File: rtl/ft232h_sync_bridge.sv
// Bridges a command FIFO (to host) and a response FIFO (from host) onto an
// FT232H in synchronous 245-FIFO mode, clocked by the chip's 60 MHz CLKOUT.
module ft232h_sync_bridge
   import ft232h_sync_bridge_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   // command FIFO (standard-read: dout valid the cycle after rd_en)
   input  logic              empty,
   output logic              rd_en,
   input  logic [DATA_W-1:0] dout,
   // response FIFO
   input  logic              full,
   output logic              wr_en,
   output logic [DATA_W-1:0] din,
   // FT232H pins
   input  logic              txe_n,
   output logic              wr_n,
   input  logic              rxf_n,
   output logic              oe_n,
   output logic              rd_n,
   inout  wire  [DATA_W-1:0] adbus
);

   ft_state_t         r_state;
   logic [DATA_W-1:0] r_tx_byte;
   logic              r_last_was_rx;

   logic w_rx_req;
   logic w_tx_req;
   logic w_pick_rx;
   logic w_pick_tx;
   logic w_rx_xfer;
   logic w_drive_bus;

   // When both directions want the bus, the one not served last goes first.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      w_rx_req  = DISABLE;
      w_tx_req  = DISABLE;
      w_pick_rx = DISABLE;
      w_pick_tx = DISABLE;
      w_rx_req  = !rxf_n && !full;
      w_tx_req  = !empty && !txe_n;
      w_pick_rx = w_rx_req && (!w_tx_req || !r_last_was_rx);
      w_pick_tx = w_tx_req && (!w_rx_req ||  r_last_was_rx);
   end

   assign w_rx_xfer   = (r_state == RX) && !rxf_n && !full;
   assign w_drive_bus = (r_state == TX_SEND);

   // Strobes follow the live flags in the same cycle so the FT232H never
   // sees a write without space or a read without data.
   assign rd_en = (r_state == IDLE && w_pick_tx) ? ENABLE : DISABLE;
   assign wr_n  = w_drive_bus ? txe_n : DISABLE_N;
   assign oe_n  = (r_state == RX_OE || r_state == RX) ? ENABLE_N : DISABLE_N;
   assign rd_n  = w_rx_xfer ? ENABLE_N : DISABLE_N;
   assign wr_en = w_rx_xfer ? ENABLE : DISABLE;
   assign din   = w_rx_xfer ? adbus : '0;

   assign adbus = w_drive_bus ? r_tx_byte : {DATA_W{1'bz}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_tx_byte     <= '0;
         r_last_was_rx <= DISABLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         case (r_state)
            IDLE: begin
               if (w_pick_rx) begin
                  r_state <= RX_OE;
               end else if (w_pick_tx) begin
                  r_state <= TX_FETCH;
               end
            end
            TX_FETCH: begin
               r_tx_byte <= dout;
               r_state   <= TX_SEND;
            end
            TX_SEND: begin
               // The byte is held on the bus until the chip has room for it.
               if (!txe_n) begin
                  r_state       <= IDLE;
                  r_last_was_rx <= DISABLE;
               end
            end
            RX_OE: begin
               r_state <= RX;
            end
            RX: begin
               if (rxf_n || full) begin
                  r_state       <= IDLE;
                  r_last_was_rx <= ENABLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule : ft232h_sync_bridge

// File: tb/tb_ft232h_sync_bridge.sv
// Directed bench for ft232h_sync_bridge: FIFO and FT232H host models with
// hand-computed expectations, sampled 1 ns after each falling edge.
module tb_ft232h_sync_bridge;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       empty;
   logic       rd_en;
   logic [7:0] dout = 8'h00;
   logic       full;
   logic       wr_en;
   logic [7:0] din;
   logic       txe_n;
   logic       wr_n;
   logic       rxf_n;
   logic       oe_n;
   logic       rd_n;
   wire  [7:0] adbus;

   int n_vec  = 0;
   int n_miss = 0;

   // command FIFO model
   logic [7:0] cmd_mem [0:7];
   int         cmd_wr = 0;
   int         cmd_rd = 0;
   // FT232H receive side (host -> FPGA)
   logic [7:0] host_mem [0:31];
   int         host_len = 0;
   int         host_idx = 0;
   // logs of what left the bridge
   logic [7:0] tx_log [0:15];
   int         tx_cnt = 0;
   logic [7:0] rsp_mem [0:31];
   int         rsp_cnt = 0;

   always #8 clk = ~clk;

   ft232h_sync_bridge dut (
      .clk   (clk),
      .rst_n (rst_n),
      .empty (empty),
      .rd_en (rd_en),
      .dout  (dout),
      .full  (full),
      .wr_en (wr_en),
      .din   (din),
      .txe_n (txe_n),
      .wr_n  (wr_n),
      .rxf_n (rxf_n),
      .oe_n  (oe_n),
      .rd_n  (rd_n),
      .adbus (adbus)
   );

   // A released bus reads as 8'hFF.
   for (genvar g = 0; g < 8; g++) begin : g_pu
      pullup (adbus[g]);
   end

   assign empty = (cmd_rd == cmd_wr);
   assign rxf_n = !(host_idx < host_len);
   assign adbus = (oe_n == 1'b0) ? host_mem[host_idx] : 8'hzz;

   always @(posedge clk) begin
      if (rd_en) begin
         dout   <= cmd_mem[cmd_rd];
         cmd_rd <= cmd_rd + 1;
      end
      if (!rd_n) begin
         host_idx <= host_idx + 1;
      end
      if (!wr_n) begin
         tx_log[tx_cnt] <= adbus;
         tx_cnt         <= tx_cnt + 1;
      end
      if (wr_en) begin
         rsp_mem[rsp_cnt] <= din;
         rsp_cnt          <= rsp_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      full  = 1'b0;
      txe_n = 1'b0;
      for (int i = 0; i < 8; i++) host_mem[i] = 8'(i + 1);
      host_len   = 8;
      cmd_mem[0] = 8'hA5;
      cmd_wr     = 1;

      // reset with both directions requesting
      repeat (3) @(negedge clk);
      #1;
      check("rst_wr_n",  32'(wr_n),  1);
      check("rst_rd_n",  32'(rd_n),  1);
      check("rst_oe_n",  32'(oe_n),  1);
      check("rst_rd_en", 32'(rd_en), 0);
      check("rst_wr_en", 32'(wr_en), 0);
      check("rst_adbus", 32'(adbus), 32'hFF);

      // single TX of 0xA5 (RX blocked by full)
      @(negedge clk); full = 1'b1; rst_n = 1'b1; #1;
      check("tx_rd_en_pulse", 32'(rd_en), 1);
      check("tx_idle_wr_n",   32'(wr_n),  1);
      @(negedge clk); #1;
      check("tx_fetch_rd_en", 32'(rd_en), 0);
      check("tx_fetch_bus",   32'(adbus), 32'hFF);
      @(negedge clk); #1;
      check("tx_send_bus",    32'(adbus), 32'hA5);
      check("tx_send_wr_n",   32'(wr_n),  0);
      @(negedge clk); #1;
      check("tx_done_wr_n",   32'(wr_n),  1);
      check("tx_done_bus",    32'(adbus), 32'hFF);
      check("tx_cnt1",        32'(tx_cnt), 1);
      check("tx_byte0",       32'(tx_log[0]), 32'hA5);

      // TX backpressure: txe_n high for 5 cycles in TX_SEND
      @(negedge clk); cmd_mem[1] = 8'hA5; cmd_wr = 2; #1;
      check("bp_rd_en", 32'(rd_en), 1);
      @(negedge clk); txe_n = 1'b1; #1;
      check("bp_fetch_rd_en", 32'(rd_en), 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         check("bp_hold_wr_n", 32'(wr_n),  1);
         check("bp_hold_bus",  32'(adbus), 32'hA5);
      end
      @(negedge clk); txe_n = 1'b0; #1;
      check("bp_send_wr_n", 32'(wr_n),  0);
      check("bp_send_bus",  32'(adbus), 32'hA5);
      @(negedge clk); #1;
      check("bp_done_wr_n", 32'(wr_n),   1);
      check("bp_tx_cnt",    32'(tx_cnt), 2);
      check("bp_byte1",     32'(tx_log[1]), 32'hA5);

      // arbitration with full mid-burst: RX first, then TX, then RX resumes
      @(negedge clk); cmd_mem[2] = 8'h5A; cmd_wr = 3; full = 1'b0; #1;
      check("arb_rx_first_rd_en", 32'(rd_en), 0);
      check("arb_idle_oe_n",      32'(oe_n),  1);
      @(negedge clk); #1;
      check("arb_turn_oe_n",  32'(oe_n),  0);
      check("arb_turn_rd_n",  32'(rd_n),  1);
      check("arb_turn_wr_en", 32'(wr_en), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         check("arb_rx_rd_n", 32'(rd_n), 0);
         check("arb_rx_din",  32'(din),  32'(i + 1));
      end
      @(negedge clk); full = 1'b1; #1;
      check("full_rd_n",  32'(rd_n),  1);
      check("full_wr_en", 32'(wr_en), 0);
      @(negedge clk); full = 1'b0; #1;
      check("arb_tx_next_rd_en", 32'(rd_en), 1);
      check("arb_tx_next_oe_n",  32'(oe_n),  1);
      @(negedge clk); #1;
      check("arb_fetch_oe_n", 32'(oe_n), 1);
      @(negedge clk); #1;
      check("arb_tx_wr_n", 32'(wr_n),  0);
      check("arb_tx_bus",  32'(adbus), 32'h5A);
      @(negedge clk); #1;
      check("arb_rx2_rd_en", 32'(rd_en), 0);
      check("arb_rx2_oe_n",  32'(oe_n),  1);
      @(negedge clk); #1;
      check("arb_rx2_turn_oe_n",  32'(oe_n),  0);
      check("arb_rx2_turn_wr_en", 32'(wr_en), 0);
      for (int i = 3; i < 8; i++) begin
         @(negedge clk); #1;
         check("resume_rd_n", 32'(rd_n), 0);
         check("resume_din",  32'(din),  32'(i + 1));
      end
      @(negedge clk); #1;
      check("arb_end_rd_n",  32'(rd_n),  1);
      check("arb_end_wr_en", 32'(wr_en), 0);
      @(negedge clk); #1;
      check("arb_end_oe_n",  32'(oe_n),    1);
      check("arb_rsp_cnt",   32'(rsp_cnt), 8);
      check("arb_tx_cnt",    32'(tx_cnt),  3);
      check("arb_tx_byte2",  32'(tx_log[2]), 32'h5A);
      check("arb_rsp3",      32'(rsp_mem[3]), 32'h04);

      // plain RX burst of 0x01..0x08
      @(negedge clk);
      for (int i = 0; i < 8; i++) host_mem[8 + i] = 8'(i + 1);
      host_len = 16;
      #1;
      check("burst_idle_oe_n", 32'(oe_n), 1);
      @(negedge clk); #1;
      check("burst_oe_fall", 32'(oe_n), 0);
      check("burst_rd_hi",   32'(rd_n), 1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); #1;
         check("burst_wr_en", 32'(wr_en), 1);
         check("burst_din",   32'(din),   32'(i + 1));
      end
      @(negedge clk); #1;
      check("burst_end_rd_n",  32'(rd_n),  1);
      check("burst_end_wr_en", 32'(wr_en), 0);
      @(negedge clk); #1;
      check("burst_idle_oe_n2", 32'(oe_n),    1);
      check("burst_rsp_cnt",    32'(rsp_cnt), 16);
      check("burst_rsp15",      32'(rsp_mem[15]), 32'h08);

      // reset while a TX byte is held on the bus
      @(negedge clk); cmd_mem[3] = 8'h77; cmd_wr = 4; #1;
      check("mid_rd_en", 32'(rd_en), 1);
      @(negedge clk); txe_n = 1'b1; #1;
      @(negedge clk); #1;
      check("mid_hold_bus",  32'(adbus), 32'h77);
      check("mid_hold_wr_n", 32'(wr_n),  1);
      @(negedge clk); rst_n = 1'b0; #1;
      check("mid_rst_bus",  32'(adbus), 32'hFF);
      check("mid_rst_wr_n", 32'(wr_n),  1);
      @(negedge clk); rst_n = 1'b1; txe_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("mid_discard_tx_cnt", 32'(tx_cnt), 3);
      check("mid_after_bus",      32'(adbus),  32'hFF);
      check("mid_after_wr_n",     32'(wr_n),   1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule : tb_ft232h_sync_bridge
